// File: rtl/mux8_pkg.sv
// Shared constants and FSM encoding for the 8-channel round-robin mux scheduler.
// No logic; types and sizes only.
// Channel count is fixed at 8, so the select width is fixed at 3 bits.
package mux8_pkg;

  localparam int NCH        = 8;
  localparam int SEL_W      = 3;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/mux8_rr_scheduler_rr_pick8.sv
// Combinational round-robin picker over 8 requests.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the result is used.
module rr_pick8
  import mux8_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] w_c;

  // Scan from the farthest slot (last itself) to the nearest (last+1).
  // Each later hit overwrites the earlier one, so the nearest set bit after last wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    w_c = '0;
    for (int k = NCH; k >= 1; k--) begin
      w_c = last + SEL_W'(k);
      if (req[w_c]) begin
        any = 1'b1;
        idx = w_c;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler driving an external 8:1 byte mux; captures and forwards the byte.
// Latency: 1 cycle decide (IDLE/HOLD) + 1 cycle select/capture; peak 1 byte per 2 cycles.
// Backpressure: out_ready=0 parks the FSM in HOLD; no further pops until the byte is taken.
module mux8_rr_scheduler
  import mux8_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req_valid,
  output logic [NCH-1:0]    req_ready,
  output logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] mux_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_chan,
  input  logic              out_ready
);

  state_t            r_state;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  r_last;
  logic              r_out_vld;
  logic [DATA_W-1:0] r_out_data;
  logic [SEL_W-1:0]  r_out_chan;

  logic              w_any;
  logic [SEL_W-1:0]  w_idx;
  logic              w_sel_vld;

  // One picker serves both the IDLE and the HOLD-exit decisions.
  rr_pick8 u_pick (
    .req  (req_valid),
    .last (r_last),
    .any  (w_any),
    .idx  (w_idx)
  );

  assign w_sel_vld = req_valid[r_sel];

  // Pop strobe: only in SELECT, only if the selected source is still holding its byte.
  always_comb begin
    req_ready = '0;
    if (r_state == SELECT && w_sel_vld) begin
      req_ready[r_sel] = 1'b1;
    end
  end

  // Scheduler FSM; sel and the output port are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_last     <= SEL_W'(NCH - 1);
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_chan <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_sel   <= w_idx;
            r_state <= SELECT;
          end
        end
        SELECT: begin
          if (w_sel_vld) begin
            r_out_data <= mux_data;
            r_out_chan <= r_sel;
            r_out_vld  <= 1'b1;
            r_last     <= r_sel;
            r_state    <= HOLD;
          end else begin
            // Source withdrew: nothing popped, fairness pointer untouched.
            r_state <= IDLE;
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_out_vld <= 1'b0;
            if (w_any) begin
              r_sel   <= w_idx;
              r_state <= SELECT;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sel       = r_sel;
  assign out_valid = r_out_vld;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Self-checking bench for mux8_rr_scheduler: directed scenarios plus randomized traffic.
// Sources are modelled as per-channel byte counts; the mux is an array indexed by sel.
// Expected grants come from a round-robin reference over the pending counts.
module tb_mux8_rr_scheduler;
  import mux8_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_valid;
  logic [7:0] req_ready;
  logic [2:0] sel;
  logic [7:0] mux_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic [2:0] out_chan;
  logic       out_ready;

  logic [7:0] mem [8];
  int         cnt [8];
  int         data_mode;
  bit         manual;
  int         mlast;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  assign mux_data = mem[sel];

  mux8_rr_scheduler #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .sel       (sel),
    .mux_data  (mux_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  // Reference arbiter: first channel with pending bytes after lst, wrapping.
  function automatic int pick(input int lst);
    for (int k = 1; k <= 8; k++) begin
      if (cnt[(lst + k) % 8] > 0) return (lst + k) % 8;
    end
    return -1;
  endfunction

  // Advance one clock; sources pop on the strobe seen before the edge.
  task automatic cycle();
    logic [7:0] pend;
    pend = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      if (pend[i]) begin
        if (cnt[i] > 0) cnt[i]--;
        if (data_mode == 1) mem[i] = 8'($urandom);
      end
    end
    if (!manual) begin
      for (int i = 0; i < 8; i++) req_valid[i] = (cnt[i] > 0);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    manual    = 1'b0;
    data_mode = 0;
    req_valid = 8'h00;
    out_ready = 1'b0;
    mlast     = 7;
    for (int i = 0; i < 8; i++) begin
      cnt[i] = 0;
      mem[i] = 8'h10 + 8'(i);
    end
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      cycle();
      n_cmp++;
      if (out_valid !== 1'b0 || req_ready !== 8'h00 || sel !== 3'd0) begin
        n_err++;
        $display("FAIL reset_idle c=%0d: out_valid=%b req_ready=%h sel=%0d, want 0/00/0", c, out_valid, req_ready, sel);
      end
    end
    n_cmp++;
    if (out_data !== 8'h00 || out_chan !== 3'd0) begin
      n_err++;
      $display("FAIL reset_outs: out_data=%h out_chan=%0d, want 00/0", out_data, out_chan);
    end
  endtask

  task automatic test_single();
    int first_rr, nrr, first_ov, nov;
    logic [7:0] rrv, ovd;
    logic [2:0] ovc;
    do_reset();
    mem[0] = 8'hA5;
    out_ready = 1'b1;
    cnt[0] = 1;
    first_rr = -1; nrr = 0; first_ov = -1; nov = 0;
    rrv = 8'h00; ovd = 8'h00; ovc = 3'd0;
    for (int c = 1; c <= 10; c++) begin
      cycle();
      if (req_ready !== 8'h00) begin
        nrr++;
        if (first_rr < 0) first_rr = c;
        rrv = req_ready;
      end
      if (out_valid === 1'b1) begin
        nov++;
        if (first_ov < 0) first_ov = c;
        ovd = out_data;
        ovc = out_chan;
      end
    end
    n_cmp++;
    if (nrr != 1 || rrv !== 8'h01 || first_rr != 2) begin
      n_err++;
      $display("FAIL single_pop: count=%0d value=%h cycle=%0d, want 1/01/2", nrr, rrv, first_rr);
    end
    n_cmp++;
    if (nov != 1 || first_ov != 3) begin
      n_err++;
      $display("FAIL single_valid: count=%0d cycle=%0d, want 1/3", nov, first_ov);
    end
    n_cmp++;
    if (ovd !== 8'hA5 || ovc !== 3'd0) begin
      n_err++;
      $display("FAIL single_data: data=%h chan=%0d, want A5/0", ovd, ovc);
    end
  endtask

  task automatic test_all_ff();
    int chans[$];
    int datas[$];
    int when[$];
    do_reset();
    for (int i = 0; i < 8; i++) cnt[i] = 1000;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && chans.size() < 9; c++) begin
      if (out_valid === 1'b1 && out_ready) begin
        chans.push_back(int'(out_chan));
        datas.push_back(int'(out_data));
        when.push_back(c);
      end
      cycle();
    end
    n_cmp++;
    if (chans.size() != 9) begin
      n_err++;
      $display("FAIL allff_count: got %0d outputs, want 9", chans.size());
    end
    for (int k = 0; k < chans.size(); k++) begin
      n_cmp++;
      if (chans[k] != k % 8 || datas[k] != 8'h10 + k % 8) begin
        n_err++;
        $display("FAIL allff_order k=%0d: chan=%0d data=%h, want %0d/%h", k, chans[k], datas[k], k % 8, 8'h10 + k % 8);
      end
      if (k > 0) begin
        n_cmp++;
        if (when[k] - when[k-1] != 2) begin
          n_err++;
          $display("FAIL allff_rate k=%0d: gap=%0d, want 2", k, when[k] - when[k-1]);
        end
      end
    end
  endtask

  task automatic test_skip();
    int grants[$];
    int exp_g[3] = '{2, 5, 2};
    do_reset();
    cnt[2] = 2;
    cnt[5] = 1;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (req_ready !== 8'h00) begin
        n_cmp++;
        if ((req_ready & ~req_valid) !== 8'h00) begin
          n_err++;
          $display("FAIL skip_unset: req_ready=%h req_valid=%h", req_ready, req_valid);
        end
        for (int i = 0; i < 8; i++) if (req_ready[i]) grants.push_back(i);
      end
      cycle();
    end
    n_cmp++;
    if (grants.size() != 3) begin
      n_err++;
      $display("FAIL skip_count: got %0d grants, want 3", grants.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (grants[k] != exp_g[k]) begin
          n_err++;
          $display("FAIL skip_order k=%0d: got ch%0d, want ch%0d", k, grants[k], exp_g[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit got;
    logic [7:0] rr_seen;
    logic [7:0] d7;
    do_reset();
    cnt[0] = 1;
    mem[0] = 8'h3C;
    mem[7] = 8'hC7;
    out_ready = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      cycle();
      if (out_valid === 1'b1) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL bp_first: out_valid never rose, want 1");
    end
    cnt[7] = 1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || out_chan !== 3'd0 || sel !== 3'd0 || req_ready !== 8'h00) begin
        n_err++;
        $display("FAIL bp_hold c=%0d: v=%b d=%h ch=%0d sel=%0d rr=%h, want 1/3C/0/0/00", c, out_valid, out_data, out_chan, sel, req_ready);
      end
    end
    out_ready = 1'b1;
    rr_seen = 8'h00;
    d7 = 8'h00;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (req_ready !== 8'h00 && rr_seen === 8'h00) rr_seen = req_ready;
      if (out_valid === 1'b1 && rr_seen !== 8'h00 && !got) begin
        got = 1'b1;
        d7 = out_data;
        n_cmp++;
        if (out_chan !== 3'd7) begin
          n_err++;
          $display("FAIL bp_chan: out_chan=%0d, want 7", out_chan);
        end
      end
    end
    n_cmp++;
    if (rr_seen !== 8'h80 || d7 !== 8'hC7) begin
      n_err++;
      $display("FAIL bp_after: req_ready=%h data=%h, want 80/C7", rr_seen, d7);
    end
  endtask

  task automatic test_withdraw();
    logic [7:0] rr_seen;
    bit got;
    do_reset();
    manual = 1'b1;
    out_ready = 1'b1;
    req_valid = 8'h08;
    cycle();
    n_cmp++;
    if (req_ready !== 8'h08) begin
      n_err++;
      $display("FAIL wd_select: req_ready=%h, want 08", req_ready);
    end
    req_valid = 8'h00;
    #1;
    n_cmp++;
    if (req_ready !== 8'h00) begin
      n_err++;
      $display("FAIL wd_drop: req_ready=%h, want 00", req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      cycle();
      n_cmp++;
      if (out_valid !== 1'b0 || req_ready !== 8'h00 || sel !== 3'd3) begin
        n_err++;
        $display("FAIL wd_idle c=%0d: v=%b rr=%h sel=%0d, want 0/00/3", c, out_valid, req_ready, sel);
      end
    end
    manual = 1'b0;
    out_ready = 1'b0;
    cnt[3] = 1;
    cnt[4] = 1;
    mem[3] = 8'h33;
    mem[4] = 8'h44;
    rr_seen = 8'h00;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      cycle();
      if (req_ready !== 8'h00 && rr_seen === 8'h00) rr_seen = req_ready;
      if (out_valid === 1'b1) got = 1'b1;
    end
    n_cmp++;
    if (rr_seen !== 8'h08 || !got || out_chan !== 3'd3 || out_data !== 8'h33) begin
      n_err++;
      $display("FAIL wd_regrant: rr=%h v=%b ch=%0d d=%h, want 08/1/3/33", rr_seen, got, out_chan, out_data);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || req_ready !== 8'h00 || sel !== 3'd0 || out_data !== 8'h00) begin
      n_err++;
      $display("FAIL wd_reset: v=%b rr=%h sel=%0d d=%h, want 0/00/0/00", out_valid, req_ready, sel, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [10:0] sbq[$];
    logic [10:0] exp_e;
    logic [7:0]  exp_rr;
    int          w;
    int          budget;
    bit          busy;
    do_reset();
    data_mode = 1;
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 8; i++) begin
        cnt[i] = $urandom_range(0, 3);
        mem[i] = 8'($urandom);
      end
      budget = 300;
      busy = 1'b1;
      while (busy && budget > 0) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (req_ready !== 8'h00) begin
          w = pick(mlast);
          exp_rr = 8'h00;
          if (w >= 0) exp_rr[w] = 1'b1;
          n_cmp++;
          if (w < 0 || req_ready !== exp_rr) begin
            n_err++;
            $display("FAIL rand_grant r=%0d: req_ready=%h, want %h", r, req_ready, exp_rr);
          end
          if (w >= 0) begin
            sbq.push_back({mem[w], 3'(w)});
            mlast = w;
          end
        end
        if (out_valid === 1'b1 && out_ready) begin
          n_cmp++;
          if (sbq.size() == 0) begin
            n_err++;
            $display("FAIL rand_extra r=%0d: unexpected output ch%0d data=%h, want none", r, out_chan, out_data);
          end else begin
            exp_e = sbq.pop_front();
            if ({out_data, out_chan} !== exp_e) begin
              n_err++;
              $display("FAIL rand_data r=%0d: data=%h ch=%0d, want %h/%0d", r, out_data, out_chan, exp_e[10:3], exp_e[2:0]);
            end
          end
        end
        cycle();
        budget--;
        busy = (out_valid === 1'b1) || (sbq.size() != 0) || (req_valid !== 8'h00);
        for (int i = 0; i < 8; i++) if (cnt[i] > 0) busy = 1'b1;
      end
      if (busy) begin
        n_cmp++;
        n_err++;
        $display("FAIL rand_timeout r=%0d: still busy after budget, want drained", r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_ff();
    test_skip();
    test_backpressure();
    test_withdraw();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
